// File: rtl/ram_share_arbiter.sv
// ram_share_arbiter: round-robin sharing of one RAM8-style memory
// among NREQ requesters using a req/gnt/ack handshake.
module ram_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       we,
  input  logic [NREQ*AW-1:0]    addr,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      rdata,
  output logic [WIDTH-1:0]      ram_in,
  output logic                  ram_load,
  output logic [AW-1:0]         ram_address,
  input  logic [WIDTH-1:0]      ram_out
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [IW-1:0]   last;
  logic [IW-1:0]   id;
  logic [IW-1:0]   win_id;
  logic            win_ok;
  logic            take;
  logic [NREQ-1:0] cand;
  logic            we_l;
  logic [AW-1:0]   addr_l;
  logic [WIDTH-1:0] wdata_l;
  logic [IW:0]     sum;
  logic [IW-1:0]   idx;

  // Requests eligible at this edge; the requester just served is masked in DONE.
  always_comb begin
    cand = '0;
    unique case (state)
      IDLE:    cand = req;
      DONE:    cand = req & ~(NREQ'(1) << id);
      default: cand = '0;
    endcase
  end

  // Round-robin search starting just after the last winner, wrapping.
  always_comb begin
    win_ok = 1'b0;
    win_id = '0;
    sum    = '0;
    idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      sum = {1'b0, last} + (IW+1)'(k);
      if (sum >= (IW+1)'(NREQ))
        sum = sum - (IW+1)'(NREQ);
      idx = sum[IW-1:0];
      if (!win_ok && cand[idx]) begin
        win_ok = 1'b1;
        win_id = idx;
      end
    end
  end

  // Next-state logic: IDLE/DONE arbitrate, ACCESS always lasts one cycle.
  always_comb begin
    state_n = state;
    take    = 1'b0;
    unique case (state)
      IDLE: begin
        if (win_ok) begin
          state_n = ACCESS;
          take    = 1'b1;
        end
      end
      ACCESS: state_n = DONE;
      DONE: begin
        if (win_ok) begin
          state_n = ACCESS;
          take    = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  // Latch the winner's request so later input changes cannot disturb it.
  always_ff @(posedge clk) begin
    if (reset) begin
      last    <= IW'(NREQ-1);
      id      <= '0;
      we_l    <= 1'b0;
      addr_l  <= '0;
      wdata_l <= '0;
    end else if (take) begin
      last    <= win_id;
      id      <= win_id;
      we_l    <= we[win_id];
      addr_l  <= addr[win_id*AW +: AW];
      wdata_l <= wdata[win_id*WIDTH +: WIDTH];
    end
  end

  // Handshake pulses and read capture; writes leave rdata untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt   <= '0;
      ack   <= '0;
      rdata <= '0;
    end else begin
      gnt <= take ? (NREQ'(1) << win_id) : '0;
      ack <= (state == ACCESS) ? gnt : '0;
      if (state == ACCESS && !we_l)
        rdata <= ram_out;
    end
  end

  assign ram_address = addr_l;
  assign ram_in      = wdata_l;
  assign ram_load    = (state == ACCESS) & we_l & ~reset;

endmodule

// File: tb/tb_ram_share_arbiter.sv
// tb_ram_share_arbiter: directed and randomized checks of the
// shared-RAM arbiter against a transaction-level reference model.
module tb_ram_share_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
  localparam int AW    = 3;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       we;
  logic [NREQ*AW-1:0]    addr;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      rdata;
  logic [WIDTH-1:0]      ram_in;
  logic                  ram_load;
  logic [AW-1:0]         ram_address;
  logic [WIDTH-1:0]      ram_out;

  logic [WIDTH-1:0] mem [8] = '{default: '0};
  logic [WIDTH-1:0] shadow [8] = '{default: '0};
  logic [WIDTH-1:0] exp_rd;
  int               m_last;
  int               vectors;
  int               miscompares;

  ram_share_arbiter #(
    .NREQ(NREQ),
    .WIDTH(WIDTH),
    .AW(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .we(we),
    .addr(addr),
    .wdata(wdata),
    .gnt(gnt),
    .ack(ack),
    .rdata(rdata),
    .ram_in(ram_in),
    .ram_load(ram_load),
    .ram_address(ram_address),
    .ram_out(ram_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_out = mem[ram_address];
  always @(posedge clk)
    if (ram_load) mem[ram_address] <= ram_in;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input int lst, input logic [3:0] m);
    int j;
    for (int k = 1; k <= NREQ; k++) begin
      j = (lst + k) % NREQ;
      if (m[j]) return j;
    end
    return -1;
  endfunction

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chk("idle_gnt", 32'(gnt), 0);
      chk("idle_ack", 32'(ack), 0);
      chk("idle_load", 32'(ram_load), 0);
      chk("idle_rdata", 32'(rdata), 32'(exp_rd));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_load", 32'(ram_load), 0);
    chk("rst_addr", 32'(ram_address), 0);
    chk("rst_in", 32'(ram_in), 0);
    reset  = 1'b0;
    m_last = NREQ - 1;
    exp_rd = '0;
  endtask

  // Requesters in s raise req together while the arbiter is idle and
  // each drops it on its grant; expected order is round-robin from m_last.
  task automatic burst(input logic [3:0] s, input logic [3:0] w,
                       input logic [11:0] al, input logic [63:0] dl);
    logic [3:0]  rem;
    logic [2:0]  ai;
    logic [15:0] di;
    int          i;
    req   = s;
    we    = w;
    addr  = al;
    wdata = dl;
    rem   = s;
    while (rem != 0) begin
      i   = rr_pick(m_last, rem);
      ai  = al[i*AW +: AW];
      di  = dl[i*WIDTH +: WIDTH];
      rem[i] = 1'b0;
      @(negedge clk);
      chk("gnt", 32'(gnt), 32'(1) << i);
      chk("ack_in_access", 32'(ack), 0);
      chk("load", 32'(ram_load), 32'(w[i]));
      chk("ram_addr", 32'(ram_address), 32'(ai));
      if (w[i]) chk("ram_in", 32'(ram_in), 32'(di));
      req[i] = 1'b0;
      @(negedge clk);
      chk("ack", 32'(ack), 32'(1) << i);
      chk("gnt_in_done", 32'(gnt), 0);
      chk("load_in_done", 32'(ram_load), 0);
      if (w[i]) shadow[ai] = di;
      else      exp_rd = shadow[ai];
      chk("rdata", 32'(rdata), 32'(exp_rd));
      m_last = i;
    end
    @(negedge clk);
    chk("gap_gnt", 32'(gnt), 0);
  endtask

  int          g [5] = '{0, 1, 2, 3, 0};
  logic [3:0]  rs;
  logic [3:0]  rw;
  logic [11:0] ra;
  logic [63:0] rd;

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    req         = '0;
    we          = '0;
    addr        = '0;
    wdata       = '0;
    exp_rd      = '0;
    m_last      = NREQ - 1;

    // Reset, then requester 2 writes 0x1234 to addr 5 and reads it back.
    do_reset();
    burst(4'b0100, 4'b0100, {3'd0, 3'd5, 3'd0, 3'd0},
          {16'h0, 16'h1234, 16'h0, 16'h0});
    burst(4'b0100, 4'b0000, {3'd0, 3'd5, 3'd0, 3'd0}, 64'h0);
    chk("rd_1234", 32'(rdata), 32'h1234);

    // All four request continuously; requester 0 stays up for a second turn.
    do_reset();
    req   = 4'hF;
    we    = 4'hF;
    addr  = {3'd3, 3'd2, 3'd1, 3'd0};
    wdata = {16'hA3, 16'hA2, 16'hA1, 16'hA0};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rr_gnt", 32'(gnt), 32'(1) << g[k]);
      chk("rr_load", 32'(ram_load), 1);
      chk("rr_addr", 32'(ram_address), 32'(g[k]));
      chk("rr_in", 32'(ram_in), 32'h00A0 + 32'(g[k]));
      if (k != 0) req[g[k]] = 1'b0;
      @(negedge clk);
      chk("rr_ack", 32'(ack), 32'(1) << g[k]);
      chk("rr_gnt0", 32'(gnt), 0);
      shadow[g[k]] = 16'(16'h00A0 + g[k]);
      m_last = g[k];
    end
    @(negedge clk);
    burst(4'hF, 4'h0, {3'd3, 3'd2, 3'd1, 3'd0}, 64'h0);

    // Pointer wrap: after requester 1, req=1011 grants 3, 0, 1.
    burst(4'b0010, 4'b0000, {3'd0, 3'd0, 3'd1, 3'd0}, 64'h0);
    burst(4'b1011, 4'b0000, {3'd3, 3'd0, 3'd1, 3'd0}, 64'h0);

    // Back-to-back write then read of addr 7.
    burst(4'b0011, 4'b0001, {3'd0, 3'd0, 3'd7, 3'd7},
          {16'h0, 16'h0, 16'h0, 16'h00FF});
    chk("b2b_rdata", 32'(rdata), 32'h00FF);

    // Reset during the ACCESS cycle of a write drops it.
    burst(4'b0001, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd3},
          {16'h0, 16'h0, 16'h0, 16'h0001});
    req   = 4'b0100;
    we    = 4'b0100;
    addr  = {3'd0, 3'd3, 3'd0, 3'd0};
    wdata = {16'h0, 16'hBEEF, 16'h0, 16'h0};
    @(negedge clk);
    chk("rstw_gnt", 32'(gnt), 32'h4);
    reset = 1'b1;
    #1;
    chk("rstw_load", 32'(ram_load), 0);
    @(negedge clk);
    reset  = 1'b0;
    req    = '0;
    m_last = NREQ - 1;
    exp_rd = '0;
    chk("rstw_ack", 32'(ack), 0);
    chk("rstw_gnt0", 32'(gnt), 0);
    chk("rstw_rdata", 32'(rdata), 0);
    burst(4'b0010, 4'b0000, {3'd0, 3'd0, 3'd3, 3'd0}, 64'h0);
    chk("rstw_keep", 32'(rdata), 32'h0001);

    // Quiet period.
    idle_cycles(10);

    // Randomized bursts against the model.
    for (int b = 0; b < 60; b++) begin
      rs = 4'($urandom);
      rw = 4'($urandom);
      ra = 12'($urandom);
      rd = {$urandom, $urandom};
      burst(rs, rw, ra, rd);
      idle_cycles($urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_share_arbiter.md
Name: ram_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one RAM8-style word memory among NREQ requesters.
- The memory has a combinational read path (out follows address) and writes on the rising clk edge when load=1.
- Each requester issues a read or write with a req/gnt/ack handshake.
- The block owns the memory's in/load/address pins and returns read data with a one-cycle ack pulse.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 16, data word width.
- AW, 3, memory address width (RAM8 = 3).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous active-high reset.
- req  in  NREQ  per-requester access request, level.
- we  in  NREQ  per-requester write enable (1 = write, 0 = read); qualified by req.
- addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW].
- wdata  in  NREQ*WIDTH  packed write data, requester i at [i*WIDTH +: WIDTH].
- gnt  out  NREQ  one-hot, high for the single ACCESS cycle of the winner.
- ack  out  NREQ  one-hot, high for the single DONE cycle of the winner.
- rdata  out  WIDTH  read result, valid while ack is high for a read.
- ram_in  out  WIDTH  to memory in.
- ram_load  out  1  to memory load.
- ram_address  out  AW  to memory address.
- ram_out  in  WIDTH  from memory out.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - state=IDLE.
  - last=NREQ-1, so requester 0 has highest priority first.
  - gnt=0, ack=0, rdata=0.
  - latched addr/wdata/we = 0, so ram_address=0, ram_in=0, ram_load=0.
- FSM, states IDLE, ACCESS, DONE:
  - IDLE: if any req bit is set at the edge, pick the winner, latch its id, we, addr and wdata, then go to ACCESS; otherwise stay in IDLE.
  - ACCESS (exactly 1 cycle):
    - gnt[id]=1.
    - ram_address and ram_in come from the latch.
    - ram_load = latched we.
    - At the closing edge, rdata <= ram_out for reads; rdata holds its previous value for writes. Then go to DONE.
  - DONE (exactly 1 cycle): ack[id]=1. At the closing edge, re-arbitrate with req masked by ~(1<<id).
    - Any unmasked req: latch the new winner and go to ACCESS (back-to-back).
    - Otherwise go to IDLE.
- Round-robin: search starts at (last+1) mod NREQ and wraps. last <= id on every IDLE/DONE->ACCESS transition.
- Latency: req sampled at edge n -> gnt during cycle n+1 -> ack/rdata during cycle n+2.
- Throughput: at most 1 access per 2 cycles.
- Requester rules:
  - Hold req, we, addr and wdata stable until gnt is seen.
  - Deassert req at the edge ending its ACCESS cycle or later. A req still high after DONE is treated as a new request.
  - Inputs changing after latching have no effect on the access in flight.
- Arbitration isolation: a req that drops before being sampled is never granted. A req rising while the FSM is busy waits for the next arbitration point.
- Outputs are registered except ram_load, which is gated: ram_load = (state==ACCESS) & we_latched & ~reset.
- Reset asserted in ACCESS: no memory write occurs, no ack is issued, and the in-flight access is dropped.
- Reset asserted in DONE: ack still shows for that cycle, then all outputs clear.
- No combinational path from req to any output.

Test Plan:
- Reset held for 2 cycles, then single requester 2 writes 0x1234 to addr 5 -> gnt=0100 for 1 cycle, ram_load=1 only that cycle, ack=0100 next cycle. Then requester 2 reads addr 5 -> ack=0100 with rdata=0x1234.
- req=1111 held continuously, all writes, addr=i, wdata=0xA0+i -> grants in order 0,1,2,3,0, each 2 cycles apart. Reading back addrs 0..3 returns 0xA0..0xA3.
- After requester 1 is served, req=1011 -> next grant goes to requester 3, then 0, then 1 (pointer wrap). Requester 1 is not granted twice in a row while others wait.
- Requester 0 writes 0x00FF to addr 7, back-to-back with requester 1 reading addr 7 -> requester 1 ack carries rdata=0x00FF. Exactly 4 cycles from first gnt to second ack.
- Reset pulsed during the ACCESS cycle of a write of 0xBEEF to addr 3 (addr 3 preloaded with 0x0001) -> ram_load stays 0, no ack, and a later read of addr 3 returns 0x0001.
- No req for 10 cycles -> state stays IDLE; gnt, ack and ram_load remain 0 and rdata unchanged.
